branch_predictor: RTL and testbench
===================================

Name: branch_predictor

Overview:
- Parametrised dynamic branch predictor for the five-stage core.
- Replaces the fixed "always not-taken, redirect from execute" policy.
- Fetch does a same-cycle lookup on the fetch PC and gets a predicted next PC.
- Execute returns the resolved outcome one entry per cycle. The block updates a direct-mapped BTB with saturating counters, flags mispredicts, and keeps performance counters.

Parameters:
XLEN, 32, address/data width.
ENTRIES, 64, BTB entries; power of two, ≥2.
CTR_BITS, 2, saturating counter width; 1..4.
RESET_PC, 32'h01000000, informational; no reset-time behaviour depends on it.

Ports:
clock  in  1  rising-edge clock
reset  in  1  synchronous, active-high
lk_pc  in  XLEN  fetch PC to look up
lk_hit  out  1  valid tag match at lk_pc
lk_taken  out  1  predicted taken (hit && counter MSB)
lk_next_pc  out  XLEN  lk_taken ? stored target : lk_pc+4
upd_valid  in  1  execute resolves a control instruction this cycle
upd_pc  in  XLEN  PC of resolved instruction
upd_is_jump  in  1  1 = jal/jalr, 0 = conditional branch
upd_taken  in  1  actual outcome
upd_target  in  XLEN  actual target (ALU result)
upd_pred_taken  in  1  lk_taken carried down the pipe with the instruction
upd_pred_target  in  XLEN  lk_next_pc carried down the pipe
upd_mispredict  out  1  combinational redirect request
flush  in  1  invalidate whole table
cnt_updates  out  32  resolved control instructions
cnt_mispredicts  out  32  mispredicts

Behaviour:
- Index: pc[IDX+1:2], where IDX = log2(ENTRIES).
- Tag: pc[XLEN-1:IDX+2].
- Entry fields: valid, tag, target, counter.
- Lookup is purely combinational, zero latency.
- Lookup reads pre-edge contents. An update to the same index in the same cycle becomes visible on the next cycle only.
- upd_mispredict = upd_valid && (upd_taken != upd_pred_taken || (upd_taken && upd_target != upd_pred_target)).
  - Forced 0 when upd_valid = 0.
  - Not-taken with pred not-taken is never a mispredict, regardless of targets.
- Update, registered at the edge when upd_valid = 1 (upd_hit = valid && tag match at upd_pc):
  - Hit, jump: counter ← max (all ones); target ← upd_target.
  - Hit, branch taken: counter ← sat+1 (stays at max); target ← upd_target.
  - Hit, branch not taken: counter ← sat-1 (stays at 0); target unchanged.
  - Miss, upd_taken = 1: allocate, replacing any resident entry. valid ← 1, tag, target ← upd_target; counter ← max for a jump, else weakly-taken 2^(CTR_BITS-1).
  - Miss, upd_taken = 0: no allocation, table unchanged.
- Counter arithmetic is unsigned CTR_BITS wide and must never wrap.
- Performance counters:
  - cnt_updates +1 per upd_valid.
  - cnt_mispredicts +1 per upd_mispredict.
  - Both wrap modulo 2^32.
- Reset:
  - All valid bits ← 0 and all counters ← 2^(CTR_BITS-1)-1 (weakly not-taken); both perf counters ← 0.
  - Consequence: lk_hit = 0, lk_taken = 0, lk_next_pc = lk_pc+4, upd_mispredict depends only on inputs.
  - Reset overrides flush and update in the same cycle.
  - Tags and targets need no reset.
- Flush:
  - Clears all valid bits in one cycle; counters and perf counters are kept.
  - Flush overrides an update in the same cycle; that update is dropped from the table but still counted in the perf counters.
- Reset asserted mid-stream:
  - The table is empty the following cycle.
  - Any in-flight upd_* arriving after deassertion is applied normally.
- Aliasing: two PCs sharing an index evict each other. No associativity.

Test Plan:
- Reset, then lk_pc = 0x01000000 → lk_hit = 0, lk_next_pc = 0x01000004, cnt_updates = 0, cnt_mispredicts = 0.
- Update pc 0x01000010, branch, taken, target 0x01000040, pred_taken = 0 → upd_mispredict = 1 that cycle. Next cycle, lookup 0x01000010 → hit, taken, next_pc = 0x01000040; counter = 2; cnt_mispredicts = 1.
- Same branch not taken twice → counter 2→1→0. Lookup predicts not-taken after the first update. A third not-taken leaves the counter at 0; a taken after saturation at 3 leaves it at 3.
- Jump at 0x01000020 to 0x01000100 resolved twice: first update mispredicts and allocates with counter 3; second (pred correct) does not mispredict. Then a jalr to 0x01000200 with pred_target 0x01000100 → mispredict, target rewritten.
- Aliasing with ENTRIES = 64: 0x01000010 and 0x01000110 share index 4. A taken update of the second evicts the first, so a lookup of 0x01000010 misses.
- Update and lookup on the same index in one cycle → lookup shows old contents. flush + upd_valid together → table empty next cycle, cnt_updates incremented. reset + flush + update together → everything at reset values.

Source files
------------

// File: rtl/branch_predictor.sv
// Dynamic branch predictor: direct-mapped BTB with saturating direction counters,
// zero-latency fetch lookup, execute-stage update, mispredict detection and perf counters.
module branch_predictor #(
    parameter int              XLEN     = 32,
    parameter int              ENTRIES  = 64,
    parameter int              CTR_BITS = 2,
    parameter logic [XLEN-1:0] RESET_PC = 32'h01000000
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [XLEN-1:0] lk_pc,
    output logic            lk_hit,
    output logic            lk_taken,
    output logic [XLEN-1:0] lk_next_pc,
    input  logic            upd_valid,
    input  logic [XLEN-1:0] upd_pc,
    input  logic            upd_is_jump,
    input  logic            upd_taken,
    input  logic [XLEN-1:0] upd_target,
    input  logic            upd_pred_taken,
    input  logic [XLEN-1:0] upd_pred_target,
    output logic            upd_mispredict,
    input  logic            flush,
    output logic [31:0]     cnt_updates,
    output logic [31:0]     cnt_mispredicts
);

    localparam int IDX   = $clog2(ENTRIES);
    localparam int TAG_W = XLEN - IDX - 2;

    localparam logic [CTR_BITS-1:0] CTR_MAX = {CTR_BITS{1'b1}};
    localparam logic [CTR_BITS-1:0] CTR_WNT = CTR_MAX >> 1;
    localparam logic [CTR_BITS-1:0] CTR_WT  = CTR_MAX ^ CTR_WNT;

    // Reject geometries the indexing scheme cannot support, and unaligned reset vectors.
    if (ENTRIES < 2 || (ENTRIES & (ENTRIES - 1)) != 0 || CTR_BITS < 1 || CTR_BITS > 4 ||
        RESET_PC[1:0] != 2'b00) begin : g_param_check
        $error("branch_predictor: illegal parameter combination");
    end

    function automatic logic [CTR_BITS-1:0] sat_inc(input logic [CTR_BITS-1:0] c);
        if (c == CTR_MAX) return c;
        else              return c + CTR_BITS'(1'b1);
    endfunction

    function automatic logic [CTR_BITS-1:0] sat_dec(input logic [CTR_BITS-1:0] c);
        if (c == {CTR_BITS{1'b0}}) return c;
        else                       return c - CTR_BITS'(1'b1);
    endfunction

    logic [ENTRIES-1:0]  valid_r;
    logic [TAG_W-1:0]    tag_r    [ENTRIES];
    logic [XLEN-1:0]     target_r [ENTRIES];
    logic [CTR_BITS-1:0] ctr_r    [ENTRIES];
    logic [31:0]         cnt_updates_r;
    logic [31:0]         cnt_mispredicts_r;

    logic [IDX-1:0]      lk_idx_s;
    logic [IDX-1:0]      upd_idx_s;
    logic                upd_hit_s;
    logic                ent_wr_s;
    logic                tgt_wr_s;
    logic [CTR_BITS-1:0] ctr_nxt_s;
    logic                unused_ok_s;

    assign lk_idx_s  = lk_pc[IDX+1:2];
    assign upd_idx_s = upd_pc[IDX+1:2];
    assign upd_hit_s = valid_r[upd_idx_s] && (tag_r[upd_idx_s] == upd_pc[XLEN-1:IDX+2]);

    // Lookup sees only pre-edge table contents, so same-index updates appear a cycle later.
    assign lk_hit     = valid_r[lk_idx_s] && (tag_r[lk_idx_s] == lk_pc[XLEN-1:IDX+2]);
    assign lk_taken   = lk_hit && ctr_r[lk_idx_s][CTR_BITS-1];
    assign lk_next_pc = lk_taken ? target_r[lk_idx_s] : (lk_pc + XLEN'(3'd4));

    assign upd_mispredict = upd_valid &&
        ((upd_taken != upd_pred_taken) || (upd_taken && (upd_target != upd_pred_target)));

    assign cnt_updates     = cnt_updates_r;
    assign cnt_mispredicts = cnt_mispredicts_r;

    // Low PC bits are always zero for aligned instructions.
    assign unused_ok_s = ^{lk_pc[1:0], upd_pc[1:0]};

    // Decide whether the resolved instruction writes its entry, and with what.
    always_comb begin
        ent_wr_s  = 1'b0;
        tgt_wr_s  = 1'b0;
        ctr_nxt_s = ctr_r[upd_idx_s];
        if (upd_valid) begin
            if (upd_hit_s) begin
                ent_wr_s = 1'b1;
                if (upd_is_jump) begin
                    ctr_nxt_s = CTR_MAX;
                    tgt_wr_s  = 1'b1;
                end else if (upd_taken) begin
                    ctr_nxt_s = sat_inc(ctr_r[upd_idx_s]);
                    tgt_wr_s  = 1'b1;
                end else begin
                    ctr_nxt_s = sat_dec(ctr_r[upd_idx_s]);
                    tgt_wr_s  = 1'b0;
                end
            end else if (upd_taken) begin
                // Allocate over whatever was resident; jumps start strongly taken.
                ent_wr_s  = 1'b1;
                tgt_wr_s  = 1'b1;
                ctr_nxt_s = upd_is_jump ? CTR_MAX : CTR_WT;
            end else begin
                ent_wr_s = 1'b0;
            end
        end else begin
            ent_wr_s = 1'b0;
        end
    end

    // Valid bits and direction counters: reset beats flush beats update.
    always_ff @(posedge clock) begin
        if (reset) begin
            valid_r <= {ENTRIES{1'b0}};
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_r[i] <= CTR_WNT;
            end
        end else if (flush) begin
            valid_r <= {ENTRIES{1'b0}};
        end else if (ent_wr_s) begin
            valid_r[upd_idx_s] <= 1'b1;
            ctr_r[upd_idx_s]   <= ctr_nxt_s;
        end
    end

    // Tag and target payload; never reset since valid gates their use.
    always_ff @(posedge clock) begin
        if (!reset && !flush && ent_wr_s) begin
            tag_r[upd_idx_s] <= upd_pc[XLEN-1:IDX+2];
            if (tgt_wr_s) begin
                target_r[upd_idx_s] <= upd_target;
            end
        end
    end

    // Performance counters keep counting through flush-dropped updates.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_updates_r     <= 32'd0;
            cnt_mispredicts_r <= 32'd0;
        end else begin
            if (upd_valid) begin
                cnt_updates_r <= cnt_updates_r + 32'd1;
            end
            if (upd_mispredict) begin
                cnt_mispredicts_r <= cnt_mispredicts_r + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed vectors with literal expectations
// plus a table-level behavioural model compared against the DUT every cycle.
module tb_branch_predictor;

    localparam int XLEN     = 32;
    localparam int ENTRIES  = 64;
    localparam int CTR_BITS = 2;
    localparam int CMAX     = (1 << CTR_BITS) - 1;
    localparam int WT       = 1 << (CTR_BITS - 1);
    localparam int WNT      = WT - 1;

    logic        clock;
    logic        reset;
    logic [31:0] lk_pc;
    logic        lk_hit;
    logic        lk_taken;
    logic [31:0] lk_next_pc;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_is_jump;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_pred_taken;
    logic [31:0] upd_pred_target;
    logic        upd_mispredict;
    logic        flush;
    logic [31:0] cnt_updates;
    logic [31:0] cnt_mispredicts;

    branch_predictor #(
        .XLEN(XLEN), .ENTRIES(ENTRIES), .CTR_BITS(CTR_BITS), .RESET_PC(32'h01000000)
    ) dut (
        .clock(clock), .reset(reset),
        .lk_pc(lk_pc), .lk_hit(lk_hit), .lk_taken(lk_taken), .lk_next_pc(lk_next_pc),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_is_jump(upd_is_jump),
        .upd_taken(upd_taken), .upd_target(upd_target),
        .upd_pred_taken(upd_pred_taken), .upd_pred_target(upd_pred_target),
        .upd_mispredict(upd_mispredict), .flush(flush),
        .cnt_updates(cnt_updates), .cnt_mispredicts(cnt_mispredicts)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Model: each slot remembers which PC region it holds and a plain integer counter.
    bit          m_valid  [ENTRIES];
    int unsigned m_tag    [ENTRIES];
    logic [31:0] m_target [ENTRIES];
    int          m_ctr    [ENTRIES];
    logic [31:0] m_upd = 32'd0;
    logic [31:0] m_mis = 32'd0;

    logic [31:0] pcs  [5] = '{32'h01000010, 32'h01000110, 32'h01000020, 32'h01000030, 32'h01000210};
    logic [31:0] tgts [3] = '{32'h01000400, 32'h01000800, 32'h02000000};

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc / 32'd4) % ENTRIES);
    endfunction

    function automatic int unsigned tag_of(input logic [31:0] pc);
        return pc / (4 * ENTRIES);
    endfunction

    function automatic bit m_hit(input logic [31:0] pc);
        return m_valid[idx_of(pc)] && (m_tag[idx_of(pc)] == tag_of(pc));
    endfunction

    function automatic bit m_taken(input logic [31:0] pc);
        return m_hit(pc) && (m_ctr[idx_of(pc)] >= WT);
    endfunction

    function automatic logic [31:0] m_next(input logic [31:0] pc);
        if (m_taken(pc)) return m_target[idx_of(pc)];
        else             return pc + 32'd4;
    endfunction

    function automatic bit m_mispredict();
        if (!upd_valid)                      return 1'b0;
        if (upd_taken != upd_pred_taken)     return 1'b1;
        if (upd_taken && upd_target != upd_pred_target) return 1'b1;
        return 1'b0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state advances on the same edge as the DUT.
    always @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                m_valid[i] = 1'b0;
                m_ctr[i]   = WNT;
            end
            m_upd = 32'd0;
            m_mis = 32'd0;
        end else begin
            if (upd_valid) m_upd = m_upd + 32'd1;
            if (m_mispredict()) m_mis = m_mis + 32'd1;
            if (flush) begin
                for (int i = 0; i < ENTRIES; i++) m_valid[i] = 1'b0;
            end else if (upd_valid) begin
                int k;
                k = idx_of(upd_pc);
                if (m_hit(upd_pc)) begin
                    if (upd_is_jump) begin
                        m_ctr[k] = CMAX;
                        m_target[k] = upd_target;
                    end else if (upd_taken) begin
                        m_ctr[k] = (m_ctr[k] < CMAX) ? m_ctr[k] + 1 : CMAX;
                        m_target[k] = upd_target;
                    end else begin
                        m_ctr[k] = (m_ctr[k] > 0) ? m_ctr[k] - 1 : 0;
                    end
                end else if (upd_taken) begin
                    m_valid[k]  = 1'b1;
                    m_tag[k]    = tag_of(upd_pc);
                    m_target[k] = upd_target;
                    m_ctr[k]    = upd_is_jump ? CMAX : WT;
                end
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clock) begin
        if (chk_en) begin
            chk("lk_hit", 32'(lk_hit), 32'(m_hit(lk_pc)));
            chk("lk_taken", 32'(lk_taken), 32'(m_taken(lk_pc)));
            chk("lk_next_pc", lk_next_pc, m_next(lk_pc));
            chk("upd_mispredict", 32'(upd_mispredict), 32'(m_mispredict()));
            chk("cnt_updates", cnt_updates, m_upd);
            chk("cnt_mispredicts", cnt_mispredicts, m_mis);
        end
    end

    task automatic resolve(input logic [31:0] pc, input bit jump, input bit taken,
                           input logic [31:0] tgt, input bit pt, input logic [31:0] ptgt,
                           input bit exp_mis);
        upd_valid = 1'b1; upd_pc = pc; upd_is_jump = jump; upd_taken = taken;
        upd_target = tgt; upd_pred_taken = pt; upd_pred_target = ptgt;
        #1;
        chk("lit_mispredict", 32'(upd_mispredict), 32'(exp_mis));
        @(posedge clock); #1;
        upd_valid = 1'b0;
    endtask

    task automatic look(input logic [31:0] pc, input bit eh, input bit et, input logic [31:0] en);
        lk_pc = pc;
        #1;
        chk("lit_hit", 32'(lk_hit), 32'(eh));
        chk("lit_taken", 32'(lk_taken), 32'(et));
        chk("lit_next_pc", lk_next_pc, en);
        @(posedge clock); #1;
    endtask

    task automatic counts(input logic [31:0] eu, input logic [31:0] em);
        #1;
        chk("lit_cnt_updates", cnt_updates, eu);
        chk("lit_cnt_mispredicts", cnt_mispredicts, em);
        @(posedge clock); #1;
    endtask

    localparam logic [31:0] B = 32'h01000010;
    localparam logic [31:0] T = 32'h01000040;
    localparam logic [31:0] F = 32'h01000014;
    localparam logic [31:0] J = 32'h01000020;
    localparam logic [31:0] JT = 32'h01000100;

    initial begin
        reset = 1'b1; flush = 1'b0; lk_pc = 32'h01000000;
        upd_valid = 1'b0; upd_pc = 32'd0; upd_is_jump = 1'b0; upd_taken = 1'b0;
        upd_target = 32'd0; upd_pred_taken = 1'b0; upd_pred_target = 32'd0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        chk_en = 1'b1;

        look(32'h01000000, 1'b0, 1'b0, 32'h01000004);
        counts(32'd0, 32'd0);

        // Branch allocation and counter walk, including both saturation limits.
        resolve(B, 1'b0, 1'b1, T, 1'b0, F, 1'b1);
        look(B, 1'b1, 1'b1, T);
        counts(32'd1, 32'd1);
        resolve(B, 1'b0, 1'b0, T, 1'b1, T, 1'b1);
        look(B, 1'b1, 1'b0, F);
        resolve(B, 1'b0, 1'b0, T, 1'b0, F, 1'b0);
        resolve(B, 1'b0, 1'b0, T, 1'b0, F, 1'b0);
        resolve(B, 1'b0, 1'b1, T, 1'b0, F, 1'b1);
        look(B, 1'b1, 1'b0, F);
        resolve(B, 1'b0, 1'b1, T, 1'b0, F, 1'b1);
        resolve(B, 1'b0, 1'b1, T, 1'b1, T, 1'b0);
        resolve(B, 1'b0, 1'b1, T, 1'b1, T, 1'b0);
        resolve(B, 1'b0, 1'b0, T, 1'b1, T, 1'b1);
        look(B, 1'b1, 1'b1, T);
        resolve(B, 1'b0, 1'b0, T, 1'b1, T, 1'b1);
        look(B, 1'b1, 1'b0, F);
        counts(32'd10, 32'd6);

        // Jumps, target rewrite, and a not-taken miss with mismatched targets.
        resolve(J, 1'b1, 1'b1, JT, 1'b0, 32'h01000024, 1'b1);
        look(J, 1'b1, 1'b1, JT);
        resolve(J, 1'b1, 1'b1, JT, 1'b1, JT, 1'b0);
        resolve(J, 1'b1, 1'b1, 32'h01000200, 1'b1, JT, 1'b1);
        look(J, 1'b1, 1'b1, 32'h01000200);
        resolve(32'h01000080, 1'b0, 1'b0, 32'd0, 1'b0, 32'h12345678, 1'b0);
        look(32'h01000080, 1'b0, 1'b0, 32'h01000084);

        // Aliasing at index 4.
        resolve(32'h01000110, 1'b0, 1'b1, 32'h01000500, 1'b0, 32'h01000114, 1'b1);
        look(B, 1'b0, 1'b0, F);
        look(32'h01000110, 1'b1, 1'b1, 32'h01000500);

        // Same-cycle lookup and update on one index.
        lk_pc = B;
        upd_valid = 1'b1; upd_pc = B; upd_is_jump = 1'b0; upd_taken = 1'b1;
        upd_target = 32'h01000600; upd_pred_taken = 1'b0; upd_pred_target = F;
        #1;
        chk("lit_same_cycle_hit", 32'(lk_hit), 32'd0);
        chk("lit_same_cycle_next", lk_next_pc, F);
        @(posedge clock); #1;
        upd_valid = 1'b0;
        look(B, 1'b1, 1'b1, 32'h01000600);
        counts(32'd16, 32'd10);

        // Flush with a concurrent update.
        flush = 1'b1;
        resolve(32'h01000030, 1'b0, 1'b1, 32'h01000700, 1'b0, 32'h01000034, 1'b1);
        flush = 1'b0;
        look(32'h01000030, 1'b0, 1'b0, 32'h01000034);
        look(B, 1'b0, 1'b0, F);
        counts(32'd17, 32'd11);

        // Reset together with flush and update.
        resolve(32'h01000040, 1'b0, 1'b1, 32'h01000800, 1'b0, 32'h01000044, 1'b1);
        look(32'h01000040, 1'b1, 1'b1, 32'h01000800);
        reset = 1'b1; flush = 1'b1;
        resolve(32'h01000050, 1'b1, 1'b1, 32'h01000900, 1'b0, 32'h01000054, 1'b1);
        reset = 1'b0; flush = 1'b0;
        look(32'h01000040, 1'b0, 1'b0, 32'h01000044);
        look(32'h01000050, 1'b0, 1'b0, 32'h01000054);
        counts(32'd0, 32'd0);

        // Updates after reset deassertion apply normally.
        resolve(32'h01000040, 1'b0, 1'b1, 32'h01000800, 1'b0, 32'h01000044, 1'b1);
        look(32'h01000040, 1'b1, 1'b1, 32'h01000800);
        counts(32'd1, 32'd1);

        // Mixed traffic over a few aliasing PCs, checked only by the model.
        for (int n = 0; n < 400; n++) begin
            lk_pc           = pcs[$urandom_range(0, 4)];
            upd_valid       = ($urandom_range(0, 3) != 0);
            upd_pc          = pcs[$urandom_range(0, 4)];
            upd_is_jump     = ($urandom_range(0, 3) == 0);
            upd_taken       = 1'($urandom_range(0, 1));
            upd_target      = tgts[$urandom_range(0, 2)];
            upd_pred_taken  = 1'($urandom_range(0, 1));
            upd_pred_target = tgts[$urandom_range(0, 2)];
            flush           = ($urandom_range(0, 29) == 0);
            reset           = ($urandom_range(0, 79) == 0);
            @(posedge clock); #1;
        end
        upd_valid = 1'b0; flush = 1'b0; reset = 1'b0;
        @(posedge clock); #1;
        @(negedge clock); #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
